ap_tile_sequencer: RTL and testbench
====================================

// Module: ap_tile_sequencer
// PURPOSE
//  Control stage directly upstream of the DDR->ibuf->DDR test path (test_axirambus).
//  Runs a job of I_tile_num tiles. For each tile it drives the path's level-sensitive
//  ap_start with a base address advanced by I_stride, then waits for the path's done pulse.
//  Reports a single ap_done/ap_ready for the whole job, plus a timeout flag.
// PARAMETERS
//  C_M_AXI_ADDR_WIDTH  32  width of DDR byte addresses (base, stride, job address)
//  C_RAM_ADDR_WIDTH    10  width of the per-tile length passed to the path
//  C_TILE_CNT_WIDTH    16  width of the tile count and tile index
//  C_GAP_CYCLES        2   cycles O_job_start is held low between tiles (min 2)
//  C_TIMEOUT_WIDTH     20  per-tile watchdog counter width
// PORTS
//  I_clk            in   1     single clock
//  I_rst_n          in   1     asynchronous active-low reset
//  I_ap_start       in   1     level start; rising edge launches a job, low aborts or returns to idle
//  O_ap_done        out  1     1-cycle pulse when the job ends (normally or on timeout)
//  O_ap_idle        out  1     1 = no job in progress
//  O_ap_ready       out  1     1-cycle pulse, same cycle as O_ap_done
//  I_base_addr      in   ADDR  DDR address for tile 0
//  I_stride         in   ADDR  address increment per tile, in raw address units (no scaling)
//  I_len            in   RAM   per-tile length, forwarded unchanged
//  I_tile_num       in   CNT   number of tiles; 0 is legal
//  O_job_start      out  1     level ap_start to the path
//  O_job_base_addr  out  ADDR  base address of the current tile
//  O_job_len        out  RAM   latched I_len
//  I_job_done       in   1     1-cycle done pulse from the path
//  O_tile_idx       out  CNT   index of the tile in flight
//  O_timeout        out  1     sticky; set on watchdog expiry, cleared at the next job launch
// BEHAVIOUR
//  Reset (async, I_rst_n=0): state IDLE; O_ap_idle=1; every other output 0.
//  Start edge: I_ap_start=1 and a 1-cycle-delayed copy of it =0 (registered internally).
//  FSM states: IDLE, LAUNCH, WAIT, GAP, DONE, HOLD.
//  - IDLE: on a start edge at cycle t, latch base, stride, len and tile_num, and clear O_timeout.
//    At t+1: O_ap_idle=0 and tile_idx=0.
//    If tile_num=0, go to DONE; otherwise go to LAUNCH.
//  - LAUNCH: O_job_start=1 and O_job_base_addr=cur_addr. Go to WAIT in the next cycle.
//  - WAIT: hold O_job_start=1. Watchdog counts up every cycle.
//    On I_job_done: if tile_idx==tile_num-1 go to DONE; otherwise go to GAP.
//    If the watchdog reaches all-ones: set O_timeout and go to DONE.
//  - GAP: O_job_start=0 for C_GAP_CYCLES cycles; then cur_addr+=stride, tile_idx++, go to LAUNCH.
//    The gap lets the path see its start fall and re-arm its rising-edge detect.
//  - DONE: O_job_start=0; O_ap_done=O_ap_ready=1 for exactly one cycle; then go to HOLD.
//  - HOLD: stay until I_ap_start=0, then go to IDLE and set O_ap_idle=1.
//    No relaunch while I_ap_start stays high.
//  Abort: I_ap_start=0 in any state other than IDLE or HOLD.
//    Next cycle: O_job_start=0, state IDLE, O_ap_idle=1. No ap_done pulse.
//  I_job_done is ignored outside WAIT.
//  Watchdog clears on entry to LAUNCH.
//  Address arithmetic is modulo 2^C_M_AXI_ADDR_WIDTH; wrap is silent.
//  The path writes to base+len, so software keeps stride >= 2*len. The block does not check this.
//  All outputs are registered. Config inputs are sampled only at the start edge.
// STRUCTURE
//  Shared package: FSM state encoding (one-hot, 6 bits).
//  Shared package: C_GAP_CYCLES minimum (2) and the watchdog all-ones constant.
//  One sub-module: ap_edge_det (registered rising-edge detect with async active-low reset).
//  The path's own ap_start edge logic can reuse it.
//  Everything else is a single FSM plus counters in this file.
// TESTING
//  1 tile_num=3, base=0x1000, stride=0x100, len=8; done 20 cycles after each launch
//    -> O_job_base_addr 0x1000, 0x1100, 0x1200; O_job_start low for 2 cycles between tiles;
//       exactly one O_ap_done pulse; O_timeout=0.
//  2 tile_num=0 -> O_job_start never rises; O_ap_done pulses 2 cycles after the start edge.
//  3 base=0xFFFF_FF00, stride=0x100, tile_num=2 -> second address is 0x0000_0000 (wrap).
//  4 I_ap_start dropped in WAIT of tile 1
//    -> O_job_start=0 next cycle; O_ap_idle=1; no O_ap_done; a later start edge restarts at tile 0.
//  5 C_TIMEOUT_WIDTH=4, I_job_done never asserted
//    -> O_timeout=1 and an O_ap_done pulse 15-16 cycles after launch.
//  6 I_rst_n asserted mid-WAIT -> all outputs 0 and O_ap_idle=1 immediately (asynchronous);
//    a stray I_job_done pulse during IDLE has no effect.

Source files
------------

// File: rtl/ap_tile_sequencer_pkg.sv
// Shared definitions for the tile sequencer: state encoding and fixed constants.
package ap_tile_sequencer_pkg;

    // One-hot FSM encoding.
    typedef enum logic [5:0] {
        StIdle   = 6'b000001,
        StLaunch = 6'b000010,
        StWait   = 6'b000100,
        StGap    = 6'b001000,
        StDone   = 6'b010000,
        StHold   = 6'b100000
    } state_e;

    // The path needs at least two low cycles on its start to re-arm its edge detect.
    localparam int unsigned GapCyclesMin = 2;

    // Watchdog expiry value; sliced down to the configured counter width.
    localparam logic [63:0] WdogAllOnes = '1;

endpackage

// File: rtl/ap_edge_det.sv
// Registered rising-edge detector with asynchronous active-low reset.
module ap_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic din_q;

    // Keep a delayed copy of the input and register the rise condition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q <= 1'b0;
            rise  <= 1'b0;
        end else begin
            din_q <= din;
            rise  <= din & ~din_q;
        end
    end

endmodule

// File: rtl/ap_tile_sequencer.sv
// Sequences a job of tiles through the DDR->ibuf->DDR path, one level-start per tile,
// and reports a single done/ready pulse for the whole job plus a sticky timeout flag.
module ap_tile_sequencer
    import ap_tile_sequencer_pkg::*;
#(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_RAM_ADDR_WIDTH   = 10,
    parameter int unsigned C_TILE_CNT_WIDTH   = 16,
    parameter int unsigned C_GAP_CYCLES       = 2,
    parameter int unsigned C_TIMEOUT_WIDTH    = 20
) (
    input  logic                          I_clk,
    input  logic                          I_rst_n,
    input  logic                          I_ap_start,
    output logic                          O_ap_done,
    output logic                          O_ap_idle,
    output logic                          O_ap_ready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] I_base_addr,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] I_stride,
    input  logic [C_RAM_ADDR_WIDTH-1:0]   I_len,
    input  logic [C_TILE_CNT_WIDTH-1:0]   I_tile_num,
    output logic                          O_job_start,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] O_job_base_addr,
    output logic [C_RAM_ADDR_WIDTH-1:0]   O_job_len,
    input  logic                          I_job_done,
    output logic [C_TILE_CNT_WIDTH-1:0]   O_tile_idx,
    output logic                          O_timeout
);

    localparam int unsigned GapCycles =
        (C_GAP_CYCLES < GapCyclesMin) ? GapCyclesMin : C_GAP_CYCLES;
    localparam int unsigned GapW = $clog2(GapCycles);
    localparam logic [GapW-1:0] GapLast = GapW'(GapCycles - 1);
    localparam logic [C_TIMEOUT_WIDTH-1:0] WdogMax = WdogAllOnes[C_TIMEOUT_WIDTH-1:0];

    state_e                        state_q, state_d;
    logic                          start_rise;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [C_RAM_ADDR_WIDTH-1:0]   len_q, len_d;
    logic [C_TILE_CNT_WIDTH-1:0]   num_q, num_d;
    logic [C_TILE_CNT_WIDTH-1:0]   idx_q, idx_d;
    logic [C_TIMEOUT_WIDTH-1:0]    wdog_q, wdog_d, wdog_inc;
    logic [GapW-1:0]               gap_q, gap_d;
    logic                          timeout_q, timeout_d;
    logic                          job_start_q, job_start_d;
    logic                          done_q, done_d;
    logic                          idle_q, idle_d;

    ap_edge_det u_start_edge (
        .clk   (I_clk),
        .rst_n (I_rst_n),
        .din   (I_ap_start),
        .rise  (start_rise)
    );

    assign wdog_inc = wdog_q + C_TIMEOUT_WIDTH'(1);

    // Next-state, counter and output decode.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        stride_d  = stride_q;
        len_d     = len_q;
        num_d     = num_q;
        idx_d     = idx_q;
        wdog_d    = wdog_q;
        gap_d     = gap_q;
        timeout_d = timeout_q;

        unique case (state_q)
            StIdle: begin
                if (start_rise) begin
                    addr_d    = I_base_addr;
                    stride_d  = I_stride;
                    len_d     = I_len;
                    num_d     = I_tile_num;
                    idx_d     = '0;
                    wdog_d    = '0;
                    timeout_d = 1'b0;
                    state_d   = (I_tile_num == '0) ? StDone : StLaunch;
                end
            end
            StLaunch: state_d = StWait;
            StWait: begin
                if (I_job_done) begin
                    gap_d   = '0;
                    state_d = (idx_q == num_q - C_TILE_CNT_WIDTH'(1)) ? StDone : StGap;
                end else begin
                    wdog_d = wdog_inc;
                    if (wdog_inc == WdogMax) begin
                        timeout_d = 1'b1;
                        state_d   = StDone;
                    end
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    addr_d  = addr_q + stride_q;
                    idx_d   = idx_q + C_TILE_CNT_WIDTH'(1);
                    wdog_d  = '0;
                    state_d = StLaunch;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            StDone: state_d = StHold;
            StHold: if (!I_ap_start) state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Dropping start mid-job abandons it without a done pulse.
        if (!I_ap_start && state_q != StIdle && state_q != StHold) begin
            state_d = StIdle;
        end

        job_start_d = (state_d == StLaunch) || (state_d == StWait);
        done_d      = (state_d == StDone);
        idle_d      = (state_d == StIdle);
    end

    // State, counters and registered outputs.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            stride_q    <= '0;
            len_q       <= '0;
            num_q       <= '0;
            idx_q       <= '0;
            wdog_q      <= '0;
            gap_q       <= '0;
            timeout_q   <= 1'b0;
            job_start_q <= 1'b0;
            done_q      <= 1'b0;
            idle_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            stride_q    <= stride_d;
            len_q       <= len_d;
            num_q       <= num_d;
            idx_q       <= idx_d;
            wdog_q      <= wdog_d;
            gap_q       <= gap_d;
            timeout_q   <= timeout_d;
            job_start_q <= job_start_d;
            done_q      <= done_d;
            idle_q      <= idle_d;
        end
    end

    assign O_ap_done       = done_q;
    assign O_ap_ready      = done_q;
    assign O_ap_idle       = idle_q;
    assign O_job_start     = job_start_q;
    assign O_job_base_addr = addr_q;
    assign O_job_len       = len_q;
    assign O_tile_idx      = idx_q;
    assign O_timeout       = timeout_q;

endmodule

// File: tb/tb_ap_tile_sequencer.sv
// Directed self-checking bench for ap_tile_sequencer.
module tb_ap_tile_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ap_start = 1'b0;
    logic        ap_start2 = 1'b0;
    logic [31:0] base = '0;
    logic [31:0] stride = '0;
    logic [9:0]  len = '0;
    logic [15:0] tile_num = '0;
    logic        job_done = 1'b0;
    logic        job_done2 = 1'b0;

    logic        ap_done, ap_idle, ap_ready, job_start, timeout;
    logic [31:0] job_addr;
    logic [9:0]  job_len;
    logic [15:0] tile_idx;

    logic        ap_done2, ap_idle2, ap_ready2, job_start2, timeout2;
    logic [31:0] job_addr2;
    logic [9:0]  job_len2;
    logic [15:0] tile_idx2;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int rise_cnt = 0;
    logic js_prev = 1'b0;

    always #5 clk = ~clk;

    ap_tile_sequencer dut (
        .I_clk           (clk),
        .I_rst_n         (rst_n),
        .I_ap_start      (ap_start),
        .O_ap_done       (ap_done),
        .O_ap_idle       (ap_idle),
        .O_ap_ready      (ap_ready),
        .I_base_addr     (base),
        .I_stride        (stride),
        .I_len           (len),
        .I_tile_num      (tile_num),
        .O_job_start     (job_start),
        .O_job_base_addr (job_addr),
        .O_job_len       (job_len),
        .I_job_done      (job_done),
        .O_tile_idx      (tile_idx),
        .O_timeout       (timeout)
    );

    ap_tile_sequencer #(.C_TIMEOUT_WIDTH(4)) dut_to (
        .I_clk           (clk),
        .I_rst_n         (rst_n),
        .I_ap_start      (ap_start2),
        .O_ap_done       (ap_done2),
        .O_ap_idle       (ap_idle2),
        .O_ap_ready      (ap_ready2),
        .I_base_addr     (base),
        .I_stride        (stride),
        .I_len           (len),
        .I_tile_num      (tile_num),
        .O_job_start     (job_start2),
        .O_job_base_addr (job_addr2),
        .O_job_len       (job_len2),
        .I_job_done      (job_done2),
        .O_tile_idx      (tile_idx2),
        .O_timeout       (timeout2)
    );

    // Count done pulses and job_start rising edges of the main instance.
    always @(negedge clk) begin
        if (ap_done) done_cnt++;
        if (job_start && !js_prev) rise_cnt++;
        js_prev = job_start;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        job_done = 1'b1;
        tick();
        job_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (ap_idle !== 1'b1) begin failures++; $display("FAIL reset_idle got %b want 1", ap_idle); end
        checks++; if (job_start !== 1'b0) begin failures++; $display("FAIL reset_job_start got %b want 0", job_start); end
        checks++; if ({ap_done, ap_ready, timeout} !== 3'b000) begin failures++; $display("FAIL reset_done_ready_to got %b want 000", {ap_done, ap_ready, timeout}); end
        checks++; if (job_addr !== 32'h0 || job_len !== 10'h0 || tile_idx !== 16'h0) begin failures++; $display("FAIL reset_data got %h/%h/%h want 0/0/0", job_addr, job_len, tile_idx); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_multi_tile();
        int d0, r0, n, lows;
        base = 32'h1000; stride = 32'h100; len = 10'd8; tile_num = 16'd3;
        d0 = done_cnt; r0 = rise_cnt;
        ap_start = 1'b1;
        tick();
        tick();
        checks++; if (ap_idle !== 1'b0) begin failures++; $display("FAIL multi_idle_low got %b want 0", ap_idle); end
        checks++; if (job_len !== 10'd8) begin failures++; $display("FAIL multi_len got %0d want 8", job_len); end
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (!job_start && n < 10) begin tick(); n++; end
            checks++; if (job_start !== 1'b1) begin failures++; $display("FAIL multi_launch%0d got %b want 1", i, job_start); end
            checks++; if (job_addr !== 32'h1000 + 32'(i) * 32'h100) begin failures++; $display("FAIL multi_addr%0d got %h want %h", i, job_addr, 32'h1000 + 32'(i) * 32'h100); end
            checks++; if (tile_idx !== 16'(i)) begin failures++; $display("FAIL multi_idx%0d got %0d want %0d", i, tile_idx, i); end
            repeat (19) tick();
            checks++; if (job_start !== 1'b1) begin failures++; $display("FAIL multi_hold%0d got %b want 1", i, job_start); end
            pulse_done();
            if (i < 2) begin
                lows = 0;
                while (!job_start && lows < 10) begin lows++; tick(); end
                checks++; if (lows != 2) begin failures++; $display("FAIL multi_gap%0d got %0d want 2", i, lows); end
            end else begin
                checks++; if ({ap_done, ap_ready} !== 2'b11) begin failures++; $display("FAIL multi_done got %b want 11", {ap_done, ap_ready}); end
                tick();
                checks++; if (ap_done !== 1'b0) begin failures++; $display("FAIL multi_done_width got %b want 0", ap_done); end
            end
        end
        repeat (3) tick();
        checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL multi_done_count got %0d want 1", done_cnt - d0); end
        checks++; if (rise_cnt - r0 != 3) begin failures++; $display("FAIL multi_launch_count got %0d want 3", rise_cnt - r0); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL multi_timeout got %b want 0", timeout); end
        checks++; if (job_start !== 1'b0 || ap_idle !== 1'b0) begin failures++; $display("FAIL multi_hold_state got %b%b want 00", job_start, ap_idle); end
        ap_start = 1'b0;
        tick();
        checks++; if (ap_idle !== 1'b1) begin failures++; $display("FAIL multi_back_idle got %b want 1", ap_idle); end
    endtask

    task automatic test_zero_tiles();
        int r0;
        r0 = rise_cnt;
        tile_num = 16'd0;
        ap_start = 1'b1;
        tick();
        checks++; if (ap_done !== 1'b0) begin failures++; $display("FAIL zero_early_done got %b want 0", ap_done); end
        tick();
        checks++; if (ap_done !== 1'b1) begin failures++; $display("FAIL zero_done got %b want 1", ap_done); end
        tick();
        checks++; if (ap_done !== 1'b0) begin failures++; $display("FAIL zero_done_width got %b want 0", ap_done); end
        checks++; if (rise_cnt != r0) begin failures++; $display("FAIL zero_no_launch got %0d want %0d", rise_cnt, r0); end
        ap_start = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        int n;
        base = 32'hFFFF_FF00; stride = 32'h100; len = 10'd4; tile_num = 16'd2;
        ap_start = 1'b1;
        n = 0;
        while (!job_start && n < 10) begin tick(); n++; end
        checks++; if (job_addr !== 32'hFFFF_FF00) begin failures++; $display("FAIL wrap_addr0 got %h want ffffff00", job_addr); end
        repeat (3) tick();
        pulse_done();
        n = 0;
        while (!job_start && n < 10) begin tick(); n++; end
        checks++; if (job_addr !== 32'h0000_0000) begin failures++; $display("FAIL wrap_addr1 got %h want 00000000", job_addr); end
        repeat (3) tick();
        pulse_done();
        checks++; if (ap_done !== 1'b1) begin failures++; $display("FAIL wrap_done got %b want 1", ap_done); end
        ap_start = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        int n, d0;
        base = 32'h2000; stride = 32'h40; len = 10'h10; tile_num = 16'd3;
        d0 = done_cnt;
        ap_start = 1'b1;
        n = 0;
        while (!job_start && n < 10) begin tick(); n++; end
        repeat (5) tick();
        pulse_done();
        n = 0;
        while (!job_start && n < 10) begin tick(); n++; end
        checks++; if (tile_idx !== 16'd1) begin failures++; $display("FAIL abort_tile1 got %0d want 1", tile_idx); end
        tick();
        tick();
        ap_start = 1'b0;
        tick();
        checks++; if (job_start !== 1'b0 || ap_idle !== 1'b1) begin failures++; $display("FAIL abort_stop got start=%b idle=%b want 0/1", job_start, ap_idle); end
        repeat (4) tick();
        checks++; if (done_cnt != d0) begin failures++; $display("FAIL abort_no_done got %0d want %0d", done_cnt, d0); end
        ap_start = 1'b1;
        tick();
        tick();
        checks++; if (job_start !== 1'b1 || tile_idx !== 16'd0 || job_addr !== 32'h2000) begin failures++; $display("FAIL abort_restart got %b/%0d/%h want 1/0/2000", job_start, tile_idx, job_addr); end
        ap_start = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int n;
        tile_num = 16'd1;
        ap_start2 = 1'b1;
        n = 0;
        while (!job_start2 && n < 10) begin tick(); n++; end
        checks++; if (job_start2 !== 1'b1) begin failures++; $display("FAIL to_launch got %b want 1", job_start2); end
        n = 0;
        while (!ap_done2 && n < 40) begin tick(); n++; end
        checks++; if (n < 15 || n > 16) begin failures++; $display("FAIL to_latency got %0d want 15..16", n); end
        checks++; if (timeout2 !== 1'b1) begin failures++; $display("FAIL to_flag got %b want 1", timeout2); end
        tick();
        ap_start2 = 1'b0;
        tick();
        checks++; if (timeout2 !== 1'b1 || ap_idle2 !== 1'b1) begin failures++; $display("FAIL to_sticky got to=%b idle=%b want 1/1", timeout2, ap_idle2); end
        tile_num = 16'd0;
        ap_start2 = 1'b1;
        tick();
        tick();
        checks++; if (timeout2 !== 1'b0) begin failures++; $display("FAIL to_clear got %b want 0", timeout2); end
        ap_start2 = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        int n, d0;
        base = 32'h3000; stride = 32'h80; len = 10'd5; tile_num = 16'd2;
        ap_start = 1'b1;
        n = 0;
        while (!job_start && n < 10) begin tick(); n++; end
        tick();
        tick();
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (job_start !== 1'b0 || ap_idle !== 1'b1) begin failures++; $display("FAIL arst_now got start=%b idle=%b want 0/1", job_start, ap_idle); end
        checks++; if (job_addr !== 32'h0 || job_len !== 10'h0 || ap_done !== 1'b0) begin failures++; $display("FAIL arst_data got %h/%h/%b want 0/0/0", job_addr, job_len, ap_done); end
        ap_start = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        d0 = done_cnt;
        pulse_done();
        tick();
        checks++; if (ap_idle !== 1'b1 || job_start !== 1'b0 || done_cnt != d0) begin failures++; $display("FAIL stray_done got idle=%b start=%b dones=%0d want 1/0/%0d", ap_idle, job_start, done_cnt, d0); end
    endtask

    initial begin
        test_reset();
        test_multi_tile();
        test_zero_tiles();
        test_wrap();
        test_abort();
        test_timeout();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
